// File: rtl/updown_sweep_ctrl.sv
// Sequencer that drives an N-bit up/down counter through a triangular lo->hi->lo sweep
// for a programmed number of passes, with start/busy/done host handshake.
module updown_sweep_ctrl #(
  parameter int unsigned N = 4,
  parameter int unsigned P = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] hi_i,
  input  logic [P-1:0] passes_i,
  input  logic [N-1:0] cnt_q_i,
  output logic         cnt_clr_o,
  output logic         cnt_en_o,
  output logic         cnt_dir_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [P-1:0] pass_cnt_o
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSeek,
    StUp,
    StDown,
    StDone
  } state_e;

  localparam logic [N-1:0] OneN = N'(1);
  localparam logic [P-1:0] OneP = P'(1);

  state_e       state_q;
  logic [N-1:0] lo_q;
  logic [N-1:0] hi_q;
  logic [P-1:0] passes_q;
  logic [P-1:0] pass_cnt_q;
  logic         err_q;

  logic cfg_ok;
  logic busy;
  logic seek_end;
  logic at_top;
  logic at_bottom;
  logic last_pass;

  assign cfg_ok    = (lo_i < hi_i) && (passes_i != '0);
  // Each compare fires one step early so the counter lands on the bound at the transition edge.
  assign seek_end  = (cnt_q_i == lo_q - OneN);
  assign at_top    = (cnt_q_i == hi_q - OneN);
  assign at_bottom = (cnt_q_i == lo_q + OneN);
  assign last_pass = ((pass_cnt_q + OneP) == passes_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      lo_q       <= '0;
      hi_q       <= '0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (busy && abort_i) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              if (cfg_ok) begin
                lo_q       <= lo_i;
                hi_q       <= hi_i;
                passes_q   <= passes_i;
                pass_cnt_q <= '0;
                state_q    <= StClear;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          StClear: state_q <= (lo_q == '0) ? StUp : StSeek;
          StSeek:  if (seek_end) state_q <= StUp;
          StUp:    if (at_top) state_q <= StDown;
          StDown: begin
            if (at_bottom) begin
              pass_cnt_q <= pass_cnt_q + OneP;
              state_q    <= last_pass ? StDone : StUp;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    busy      = 1'b0;
    cnt_clr_o = 1'b0;
    cnt_en_o  = 1'b0;
    cnt_dir_o = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      StClear: begin
        busy      = 1'b1;
        cnt_clr_o = 1'b1;
      end
      StSeek, StUp: begin
        busy      = 1'b1;
        cnt_en_o  = 1'b1;
        cnt_dir_o = 1'b1;
      end
      StDown: begin
        busy     = 1'b1;
        cnt_en_o = 1'b1;
      end
      StDone:  done_o = 1'b1;
      default: ;
    endcase
    // Abort gates the counter in the same cycle it is raised.
    if (busy && abort_i) begin
      cnt_clr_o = 1'b0;
      cnt_en_o  = 1'b0;
    end
  end

  assign busy_o     = busy;
  assign err_o      = err_q;
  assign pass_cnt_o = pass_cnt_q;

endmodule
